// File: rtl/mc_core_bus.sv
// Multicycle MIPS-subset core with a valid/ack memory bus, trapping, halt detection and retire strobe.
// Define MC_CORE_LED_TRACE_EN to drive led from the WB write of the instruction fetched from LED_PC.
module mc_core_bus #(
  parameter int          ADDR_W     = 10,
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter bit          LOGIC_ZEXT = 1'b1
`ifdef MC_CORE_LED_TRACE_EN
  ,
  parameter logic [31:0] LED_PC     = 32'd148
`endif
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       pc_out,
  output logic              retire,
  output logic              halted,
  output logic              trap,
  output logic [7:0]        led
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, MEMADR, MEMRD, MEMWR, WB, BRANCH, JUMP, HALT, TRAP
  } state_t;

  state_t             state;
  logic [31:0]        pc, ir, alu_out, mdr, br_target;
  logic signed [31:0] a, b;
  logic [31:0]        rf [0:31];

  logic [5:0]         op, funct;
  logic [4:0]         rs, rt, rd;
  logic signed [31:0] imm_sext;
  logic [31:0]        imm_lext;
  logic               is_rtype, r_alu, is_jr, i_alu, is_lw, is_sw, is_br, is_j, is_jal;
  logic               self_jump, taken;
  logic [31:0]        alu_res, eff_addr, jump_target, jump_pc;
  logic               rf_we;
  logic [4:0]         rf_waddr;
  logic [31:0]        rf_wdata;

  assign op       = ir[31:26];
  assign rs       = ir[25:21];
  assign rt       = ir[20:16];
  assign rd       = ir[15:11];
  assign funct    = ir[5:0];
  assign imm_sext = {{16{ir[15]}}, ir[15:0]};
  assign imm_lext = LOGIC_ZEXT ? {16'd0, ir[15:0]} : imm_sext;

  assign is_rtype = (op == 6'h00);
  assign r_alu    = is_rtype && (funct == 6'h21 || funct == 6'h23 || funct == 6'h24 ||
                                 funct == 6'h25 || funct == 6'h2a);
  assign is_jr    = is_rtype && (funct == 6'h08);
  assign i_alu    = (op == 6'h09) || (op == 6'h0a) || (op == 6'h0c) || (op == 6'h0d);
  assign is_lw    = (op == 6'h23);
  assign is_sw    = (op == 6'h2b);
  assign is_br    = (op == 6'h04) || (op == 6'h05);
  assign is_j     = (op == 6'h02);
  assign is_jal   = (op == 6'h03);

  // pc already points past the current instruction, so pc-4 is its own address
  assign jump_target = {pc[31:28], ir[25:0], 2'b00};
  assign self_jump   = is_j && (jump_target == pc - 32'd4);
  assign jump_pc     = is_jr ? $unsigned(a) : jump_target;
  assign taken       = (a == b) ^ (op == 6'h05);
  assign eff_addr    = a + imm_sext;
  assign pc_out      = pc;

  always_comb begin
    alu_res = '0;
    if (is_rtype) begin
      case (funct)
        6'h21:   alu_res = a + b;
        6'h23:   alu_res = a - b;
        6'h24:   alu_res = a & b;
        6'h25:   alu_res = a | b;
        6'h2a:   alu_res = {31'd0, a < b};
        default: alu_res = '0;
      endcase
    end else begin
      case (op)
        6'h09:   alu_res = a + imm_sext;
        6'h0a:   alu_res = {31'd0, a < imm_sext};
        6'h0c:   alu_res = a & imm_lext;
        6'h0d:   alu_res = a | imm_lext;
        default: alu_res = '0;
      endcase
    end
  end

  // jal links in JUMP; everything else that writes does so in WB
  always_comb begin
    rf_we    = (state == WB) || (state == JUMP && is_jal);
    rf_waddr = rt;
    rf_wdata = alu_out;
    if (state == JUMP) begin
      rf_waddr = 5'd31;
      rf_wdata = pc;
    end else if (is_lw) begin
      rf_wdata = mdr;
    end else if (is_rtype) begin
      rf_waddr = rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rf_we && rf_waddr != 5'd0) rf[rf_waddr] <= rf_wdata;
  end

  always_ff @(posedge clk) begin
    case (state)
      FETCH:  if (mem_req && mem_ack) ir <= mem_rdata;
      DECODE: begin
        a         <= (rs == 5'd0) ? '0 : rf[rs];
        b         <= (rt == 5'd0) ? '0 : rf[rt];
        br_target <= pc + {imm_sext[29:0], 2'b00};
      end
      EXEC:   alu_out <= alu_res;
      MEMADR: begin
        alu_out   <= eff_addr;
        mem_wdata <= b;
      end
      MEMRD:  if (mem_ack) mdr <= mem_rdata;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= RESET_PC[ADDR_W+1:2];
      retire   <= 1'b0;
      halted   <= 1'b0;
      trap     <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        // the first fetch after reset spends one cycle raising the request
        FETCH: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            pc      <= pc + 32'd4;
            state   <= DECODE;
          end
        end
        DECODE: begin
          if (r_alu || i_alu) begin
            state <= EXEC;
          end else if (is_lw || is_sw) begin
            state <= MEMADR;
          end else if (is_br) begin
            state  <= BRANCH;
            retire <= 1'b1;
          end else if (is_j || is_jal || is_jr) begin
            state  <= JUMP;
            retire <= !self_jump;
          end else begin
            state <= TRAP;
            trap  <= 1'b1;
          end
        end
        EXEC: begin
          state  <= WB;
          retire <= 1'b1;
        end
        MEMADR: begin
          if (eff_addr[1:0] != 2'b00) begin
            state <= TRAP;
            trap  <= 1'b1;
          end else begin
            mem_req  <= 1'b1;
            mem_we   <= is_sw;
            mem_addr <= eff_addr[ADDR_W+1:2];
            state    <= is_sw ? MEMWR : MEMRD;
          end
        end
        MEMRD: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            retire  <= 1'b1;
            state   <= WB;
          end
        end
        MEMWR: begin
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_addr <= pc[ADDR_W+1:2];
            retire   <= 1'b1;
            state    <= FETCH;
          end
        end
        WB: begin
          mem_req  <= 1'b1;
          mem_addr <= pc[ADDR_W+1:2];
          state    <= FETCH;
        end
        BRANCH: begin
          mem_req <= 1'b1;
          state   <= FETCH;
          if (taken) begin
            pc       <= br_target;
            mem_addr <= br_target[ADDR_W+1:2];
          end else begin
            mem_addr <= pc[ADDR_W+1:2];
          end
        end
        JUMP: begin
          if (self_jump) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            pc       <= jump_pc;
            mem_addr <= jump_pc[ADDR_W+1:2];
            mem_req  <= 1'b1;
            state    <= FETCH;
          end
        end
        HALT:    state <= HALT;
        TRAP:    state <= TRAP;
        default: state <= TRAP;
      endcase
    end
  end

`ifdef MC_CORE_LED_TRACE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led <= 8'h00;
    end else if (state == WB && rf_we && (pc - 32'd4) == LED_PC) begin
      led <= rf_wdata[7:0];
    end
  end
`else
  assign led = 8'h00;
`endif

endmodule

// File: tb/tb_mc_core_bus.sv
// Directed bench for mc_core_bus: unified word memory with programmable wait states,
// small hand-assembled programs, results read back from memory after halt/trap.
module tb_mc_core_bus;
  localparam int          ADDR_W = 10;
  localparam logic [31:0] RPC    = 32'h40;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              mem_req, mem_we, mem_ack, retire, halted, trap;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata, pc_out;
  logic [7:0]        led;

  always #5 clk = ~clk;

  mc_core_bus #(.ADDR_W(ADDR_W), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .pc_out(pc_out),
    .retire(retire), .halted(halted), .trap(trap), .led(led)
  );

  logic [31:0] prog [0:1023];
  logic [31:0] mem  [0:1023];
  int wait_cycles = 0;
  int watch_addr  = 0;
  int wcnt, cyc, ret_n, ack_n, req_n, wr_n, viol, watch_start;
  int ret_cyc [64];
  logic [31:0] first_wa, first_wd, h_wd;
  logic [ADDR_W-1:0] h_addr;
  logic hold, h_we;
  int n_checks = 0;
  int n_errors = 0;

  assign mem_ack   = mem_req && (wcnt >= wait_cycles);
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= prog[i];
    end else if (mem_req && mem_we && mem_ack) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc <= 0; wcnt <= 0; ret_n <= 0; ack_n <= 0; req_n <= 0; wr_n <= 0; viol <= 0;
      watch_start <= -1; hold <= 1'b0; first_wa <= '0; first_wd <= '0;
      h_addr <= '0; h_we <= 1'b0; h_wd <= '0;
    end else begin
      cyc <= cyc + 1;
      wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;
      if (mem_req) req_n <= req_n + 1;
      if (mem_ack) ack_n <= ack_n + 1;
      if (mem_req && mem_we && mem_ack) begin
        wr_n <= wr_n + 1;
        if (wr_n == 0) begin
          first_wa <= 32'(mem_addr);
          first_wd <= mem_wdata;
        end
      end
      if (retire && ret_n < 64) begin
        ret_cyc[ret_n] <= cyc;
        ret_n <= ret_n + 1;
      end
      if (mem_req && !mem_we && int'(mem_addr) == watch_addr && watch_start < 0) watch_start <= cyc;
      if (hold && (!mem_req || mem_addr != h_addr || mem_we != h_we || mem_wdata != h_wd)) viol <= viol + 1;
      hold <= mem_req && !mem_ack;
      h_addr <= mem_addr; h_we <= mem_we; h_wd <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] j_ins(input logic [5:0] op, input int w);
    return {op, w[25:0]};
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 1024; i++) prog[i] = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_alu();
    clear_prog();
    prog[16] = i_ins(6'h09, 0, 1, 5);
    prog[17] = i_ins(6'h09, 0, 2, -3);
    prog[18] = r_ins(1, 2, 3, 6'h21);
    prog[19] = r_ins(2, 1, 4, 6'h2a);
    prog[20] = r_ins(1, 2, 5, 6'h23);
    prog[21] = r_ins(1, 2, 6, 6'h24);
    prog[22] = r_ins(1, 2, 7, 6'h25);
    prog[23] = i_ins(6'h0c, 2, 8, 'hFFFF);
    prog[24] = i_ins(6'h0d, 0, 9, 'h8000);
    prog[25] = i_ins(6'h0a, 1, 10, -1);
    prog[26] = i_ins(6'h09, 0, 11, 7);
    prog[27] = i_ins(6'h05, 1, 2, 1);
    prog[28] = i_ins(6'h09, 0, 11, 99);
    prog[29] = i_ins(6'h04, 1, 2, 1);
    prog[30] = i_ins(6'h09, 0, 12, 3);
    for (int k = 0; k < 10; k++) prog[31 + k] = i_ins(6'h2b, 0, 3 + k, 'h200 + 4 * k);
    prog[41] = j_ins(6'h02, 41);
  endtask

  logic [31:0] alu_exp [10] = '{32'd2, 32'd1, 32'd8, 32'd5, 32'hFFFFFFFD,
                                32'h0000FFFD, 32'h00008000, 32'd0, 32'd7, 32'd3};

  initial begin
    int snap, lw_ret;
    // reset state and first fetch, then ALU program
    load_alu();
    wait_cycles = 0;
    watch_addr  = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_retire", retire, 0);
    check("rst_halted", halted, 0);
    check("rst_trap", trap, 0);
    check("rst_led", led, 0);
    check("rst_pc", pc_out, RPC);
    rst = 1'b0;
    @(negedge clk);
    check("fetch0_req", mem_req, 1);
    check("fetch0_addr", mem_addr, 16);
    check("fetch0_we", mem_we, 0);
    @(negedge clk);
    check("pc_after_ack", pc_out, 32'h44);
    for (int i = 0; i < 500 && !halted; i++) @(negedge clk);
    check("alu_halted", halted, 1);
    check("alu_trap", trap, 0);
    for (int k = 0; k < 4; k++) check($sformatf("alu_retire_cyc%0d", k), ret_cyc[k], 4 * (k + 1));
    for (int k = 0; k < 10; k++) check($sformatf("alu_res_r%0d", k + 3), mem[128 + k], alu_exp[k]);
    check("alu_retire_count", ret_n, 24);
    check("alu_halt_pc", pc_out, 32'hA8);
    snap = req_n;
    repeat (10) @(negedge clk);
    check("halt_no_req", req_n, snap);

    // sw then lw with three wait states per access
    clear_prog();
    prog[16] = i_ins(6'h09, 0, 1, 5);
    prog[17] = i_ins(6'h2b, 0, 1, 8);
    prog[18] = i_ins(6'h23, 0, 5, 8);
    prog[19] = i_ins(6'h2b, 0, 5, 'h208);
    prog[20] = j_ins(6'h02, 20);
    wait_cycles = 3;
    watch_addr  = 18;
    do_reset();
    for (int i = 0; i < 500 && !halted; i++) @(negedge clk);
    check("ws_halted", halted, 1);
    check("ws_first_wr_addr", first_wa, 2);
    check("ws_first_wr_data", first_wd, 5);
    check("ws_lw_result", mem[130], 5);
    check("ws_retire_count", ret_n, 4);
    lw_ret = -1;
    for (int i = 0; i < ret_n; i++) if (lw_ret < 0 && ret_cyc[i] > watch_start) lw_ret = ret_cyc[i];
    check("ws_lw_cycles", lw_ret - watch_start + 1, 11);
    check("ws_bus_stable", viol, 0);

    // misaligned load traps before any data request
    clear_prog();
    prog[16] = i_ins(6'h23, 0, 5, 6);
    prog[17] = j_ins(6'h02, 17);
    wait_cycles = 0;
    do_reset();
    for (int i = 0; i < 100 && !trap; i++) @(negedge clk);
    check("mis_trap", trap, 1);
    repeat (20) @(negedge clk);
    check("mis_req_cycles", req_n, 1);
    check("mis_acks", ack_n, 1);
    check("mis_req_low", mem_req, 0);
    check("mis_halted", halted, 0);
    check("mis_retire", ret_n, 0);

    // illegal opcode
    clear_prog();
    prog[16] = 32'hFC000000;
    do_reset();
    for (int i = 0; i < 100 && !trap; i++) @(negedge clk);
    check("ill_trap", trap, 1);
    check("ill_retire", ret_n, 0);

    // recursive fib(10) via jal/jr, final r2 write at byte address 0x94
    clear_prog();
    prog[16] = i_ins(6'h09, 0, 29, 'h0FF0);
    prog[17] = i_ins(6'h09, 0, 4, 10);
    prog[18] = j_ins(6'h03, 40);
    for (int w = 19; w < 37; w++) prog[w] = r_ins(0, 0, 0, 6'h21);
    prog[37] = r_ins(2, 0, 2, 6'h21);
    prog[38] = i_ins(6'h2b, 0, 2, 'h200);
    prog[39] = j_ins(6'h02, 39);
    prog[40] = i_ins(6'h0a, 4, 8, 2);
    prog[41] = i_ins(6'h04, 8, 0, 2);
    prog[42] = r_ins(4, 0, 2, 6'h21);
    prog[43] = r_ins(31, 0, 0, 6'h08);
    prog[44] = i_ins(6'h09, 29, 29, -12);
    prog[45] = i_ins(6'h2b, 29, 31, 0);
    prog[46] = i_ins(6'h2b, 29, 4, 4);
    prog[47] = i_ins(6'h09, 4, 4, -1);
    prog[48] = j_ins(6'h03, 40);
    prog[49] = i_ins(6'h2b, 29, 2, 8);
    prog[50] = i_ins(6'h23, 29, 4, 4);
    prog[51] = i_ins(6'h09, 4, 4, -2);
    prog[52] = j_ins(6'h03, 40);
    prog[53] = i_ins(6'h23, 29, 8, 8);
    prog[54] = r_ins(2, 8, 2, 6'h21);
    prog[55] = i_ins(6'h23, 29, 31, 0);
    prog[56] = i_ins(6'h09, 29, 29, 12);
    prog[57] = r_ins(31, 0, 0, 6'h08);
    do_reset();
    for (int i = 0; i < 20000 && !halted; i++) @(negedge clk);
    check("fib_halted", halted, 1);
    check("fib_trap", trap, 0);
    check("fib_result", mem[128], 55);
`ifdef MC_CORE_LED_TRACE_EN
    check("fib_led", led, 8'd55);
`else
    check("fib_led", led, 8'd0);
`endif

    // reset during a stalled fetch
    load_alu();
    wait_cycles = 40;
    do_reset();
    repeat (5) @(negedge clk);
    check("stall_req_pre", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    check("stall_req_async", mem_req, 0);
    check("stall_pc", pc_out, RPC);
    repeat (2) @(negedge clk);
    wait_cycles = 0;
    rst = 1'b0;
    @(negedge clk);
    check("restart_req", mem_req, 1);
    check("restart_addr", mem_addr, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/mc_core_bus.md
Name: mc_core_bus

Overview:
- Parametrised multicycle MIPS-subset core, next generation of the team's multicycle CPU.
- Replaces the fixed single-cycle internal BRAM access with a valid/ack memory bus that accepts wait states.
- Adds a parametrised address space and reset PC, misalignment/illegal-opcode trapping, halt detection and a retire strobe.
- Sits between the board top and a unified instruction/data memory or arbiter.

Parameters:
- ADDR_W, 10, word-address width of mem_addr; byte addresses above ADDR_W+2 bits wrap.
- RESET_PC, 32'h0, PC value loaded at reset (must be word aligned).
- LOGIC_ZEXT, 1, 1: andi/ori zero-extend imm16; 0: sign-extend.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- mem_req  out  1  bus request, held until acked.
- mem_we  out  1  write strobe, valid with mem_req.
- mem_addr  out  ADDR_W  word address = byte_addr[ADDR_W+1:2].
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data, valid in the cycle mem_ack=1.
- mem_ack  in  1  completes current request; may be high in the same cycle as mem_req (zero-wait).
- pc_out  out  32  architectural PC.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  sticky, set on a j to its own address.
- trap  out  1  sticky, set on illegal opcode/funct or misaligned lw/sw.
- led  out  8  trace byte (see Optional Feature).

Behaviour:
- Reset (async, rst=1): pc=RESET_PC, state=FETCH, mem_req=0, mem_we=0, retire=0, halted=0, trap=0, led=0.
- Register file: 32x32, r0 reads 0 and writes to it are ignored. Register contents are not reset.
- ISA:
  - R-type: addu, subu, and, or, slt (signed), jr.
  - I-type: addiu, andi, ori, slti, lw, sw, beq, bne.
  - J-type: j, jal (writes r31 = pc+4).
- No delay slots.
- FSM states: FETCH, DECODE, EXEC, MEMADR, MEMRD, MEMWR, WB, BRANCH, JUMP, HALT, TRAP.
  - FETCH: mem_req=1, mem_we=0, addr=pc. Stay while mem_ack=0. On ack: IR<=mem_rdata, pc<=pc+4, go to DECODE.
  - DECODE: read rs/rt into A/B, compute branch target pc+(sext(imm)<<2). Dispatch:
    - R-ALU/I-ALU -> EXEC
    - lw/sw -> MEMADR
    - beq/bne -> BRANCH
    - j/jal/jr -> JUMP
    - other -> TRAP
  - EXEC: ALUOut<=result, go to WB.
  - WB: write rd (R) or rt (I), or the lw data. Pulse retire, go to FETCH.
  - MEMADR: addr=A+sext(imm). If addr[1:0]!=0 -> TRAP, else go to MEMRD or MEMWR.
  - MEMRD: hold req until ack, latch data, go to WB.
  - MEMWR: mem_we=1, wdata=B. Hold until ack, pulse retire, go to FETCH.
  - BRANCH: taken if (A==B)^bne; if taken, pc<=target. Pulse retire, go to FETCH.
  - JUMP:
    - j/jal: pc<={pc[31:28],imm26,2'b00}.
    - jr: pc<=A.
    - jal also writes r31.
    - If j target == address of the jump itself -> HALT instead.
    - Otherwise pulse retire, go to FETCH.
  - HALT and TRAP: terminal. No bus requests; exit only via rst.
- Cycle counts at zero-wait memory:
  - ALU: 4.
  - lw: 5.
  - sw: 4.
  - branch: 3.
  - jump: 3.
  - Each bus wait cycle adds 1.
- Bus rule: mem_req, mem_we, mem_addr and mem_wdata are stable from request until the ack cycle. The request drops the cycle after ack unless the next state also requests.
- Arithmetic: all 32-bit, overflow ignored (wraps). slt/slti compare signed.
- rst asserted mid-access abandons the transaction immediately. The memory must tolerate a dropped request.

Optional Feature:
- Macro: MC_CORE_LED_TRACE_EN.
- Defined: parameter LED_PC (default 32'd148) is added. When a WB write occurs for the instruction fetched from LED_PC, led <= written value[7:0].
- Undefined: led is held at 0 and LED_PC does not exist.

Test Plan:
- Reset with RESET_PC=32'h40, zero-wait memory -> first mem_req with mem_addr=16; pc_out=32'h44 after the ack.
- addiu r1,r0,5; addiu r2,r0,-3; addu r3,r1,r2; slt r4,r2,r1 -> r3=2, r4=1; retire pulses at cycles 4, 8, 12, 16.
- sw r1,8(r0) then lw r5,8(r0), with 3 wait cycles per access -> write to word 2 of 5, r5=5; lw takes 5+3+3=11 cycles.
- lw from byte address 6 -> trap=1, no mem_req for the data phase, no further requests.
- Recursive fib(10) via jal/jr ending in "j self" -> halted=1, r2=55; with MC_CORE_LED_TRACE_EN, led=8'd55.
- rst pulse in the middle of a stalled FETCH -> mem_req drops asynchronously; after release, fetch restarts at RESET_PC.
